// File: rtl/ltc2333_read.sv
// LTC2333 SDO read-back: deserialises retimed SDO bits into per-channel words and
// buffers them in a first-word-fall-through FIFO with a stream handshake.
module ltc2333_read #(
  parameter int unsigned WORD_BITS  = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NCHAN_MAX  = 8
) (
  input  logic        clk,
  input  logic        local_aresetn,
  input  logic        frame_start,
  input  logic        bit_valid,
  input  logic        sdo,
  input  logic [3:0]  n_chan,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        overflow,
  output logic        frame_err,
  output logic [15:0] drop_cnt
);

  localparam int unsigned BcW  = $clog2(WORD_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  NchanMax = 5'(NCHAN_MAX);
  localparam logic [BcW-1:0] LastBit = BcW'(WORD_BITS - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

  state_e               state_q, state_d;
  logic [BcW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]           word_cnt_q, word_cnt_d;
  logic [3:0]           nchan_q, nchan_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 discard_q, discard_d;
  logic                 frame_err_q, frame_err_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [31:0]          pend_data_q, pend_data_d;
  logic                 pend_last_q, pend_last_d;

  logic [32:0]          mem_q [FIFO_DEPTH];
  logic [32:0]          mem_d [FIFO_DEPTH];
  logic [PtrW:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]        rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic                 nchan_ok;
  logic                 fifo_empty, fifo_full;
  logic                 pop, push, drop;
  logic [32:0]          rd_entry;

  assign nchan_ok = (n_chan != 4'd0) && ({1'b0, n_chan} <= NchanMax);

  // Frame capture FSM
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    nchan_d      = nchan_q;
    shreg_d      = shreg_q;
    discard_d    = discard_q;
    frame_err_d  = frame_err_q;
    pend_valid_d = 1'b0;
    pend_data_d  = pend_data_q;
    pend_last_d  = pend_last_q;

    unique case (state_q)
      StIdle, StHold: begin
        if (frame_start) begin
          if (nchan_ok) begin
            state_d    = StCapture;
            nchan_d    = n_chan;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      StCapture: begin
        if (frame_start) begin
          // Abort: partial word is lost and the configuration frame counts as consumed.
          frame_err_d = 1'b1;
          discard_d   = 1'b0;
          if (nchan_ok) begin
            nchan_d    = n_chan;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (bit_valid) begin
          shreg_d = {shreg_q[WORD_BITS-2:0], sdo};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d    = '0;
            word_cnt_d   = word_cnt_q + 4'd1;
            pend_valid_d = !discard_q;
            pend_data_d  = {5'b0, shreg_d[2:0], shreg_d[5:3], 3'b0, shreg_d[23:6]};
            pend_last_d  = (word_cnt_q == nchan_q - 4'd1);
            if (word_cnt_q == nchan_q - 4'd1) begin
              state_d   = StHold;
              discard_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BcW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output FIFO; a push onto a full FIFO is accepted when a pop frees a slot in the same cycle.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop        = !fifo_empty && m_tready;
  assign push       = pend_valid_q && (!fifo_full || pop);
  assign drop       = pend_valid_q && fifo_full && !pop;
  assign rd_entry   = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = {pend_last_q, pend_data_q};
      wr_ptr_d                  = wr_ptr_q + (PtrW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge local_aresetn) begin
    if (!local_aresetn) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      nchan_q      <= '0;
      shreg_q      <= '0;
      discard_q    <= 1'b1;
      frame_err_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_last_q  <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      nchan_q      <= nchan_d;
      shreg_q      <= shreg_d;
      discard_q    <= discard_d;
      frame_err_q  <= frame_err_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_last_q  <= pend_last_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign m_tvalid  = !fifo_empty;
  assign m_tdata   = fifo_empty ? 32'd0 : rd_entry[31:0];
  assign m_tlast   = !fifo_empty && rd_entry[32];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ltc2333_read.sv
// Directed-plus-random bench for ltc2333_read; expected stream comes from a queue model
// of frames, discard frame, 4-entry buffer and drop counting.
module tb_ltc2333_read;

  logic        clk = 1'b0;
  logic        local_aresetn = 1'b0;
  logic        frame_start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        sdo = 1'b0;
  logic [3:0]  n_chan = 4'd0;
  logic        m_tready = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        overflow;
  logic        frame_err;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data [$];
  bit          exp_last [$];
  bit          disc;
  int          drops;
  bit          ovf;
  logic [23:0] fw [8];

  ltc2333_read #(
    .WORD_BITS (24),
    .FIFO_DEPTH(4),
    .NCHAN_MAX (8)
  ) dut (
    .clk          (clk),
    .local_aresetn(local_aresetn),
    .frame_start  (frame_start),
    .bit_valid    (bit_valid),
    .sdo          (sdo),
    .n_chan       (n_chan),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] pack(input logic [23:0] w);
    int unsigned v;
    v = 32'(w);
    return ((v % 8) << 24) | (((v / 8) % 8) << 21) | (v / 64);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_word(input logic [23:0] w, input bit last);
    if (!disc) begin
      if (exp_data.size() < 4) begin
        exp_data.push_back(pack(w));
        exp_last.push_back(last);
      end else begin
        ovf = 1'b1;
        if (drops < 65535) drops++;
      end
    end
    if (last) disc = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_tvalid), 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_tlast"}, 32'(m_tlast), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  task automatic do_reset(input string tag);
    local_aresetn = 1'b0;
    frame_start   = 1'b0;
    bit_valid     = 1'b0;
    m_tready      = 1'b0;
    disc          = 1'b1;
    drops         = 0;
    ovf           = 1'b0;
    exp_data.delete();
    exp_last.delete();
    #1;
    check_reset_outputs(tag);
    step();
    step();
    local_aresetn = 1'b1;
    step();
  endtask

  task automatic pulse(input logic [3:0] n);
    frame_start = 1'b1;
    n_chan      = n;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      bit_valid = 1'b1;
      sdo       = w[23-i];
      step();
      bit_valid = 1'b0;
      sdo       = 1'($urandom);
      if (i != nb - 1) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) fw[i] = 24'($urandom);
  endtask

  // Optional pop_last raises m_tready for exactly the cycle the final word is written.
  task automatic run_frame(input int n, input bit pop_last);
    pulse(4'(n));
    for (int i = 0; i < n; i++) begin
      send_bits(fw[i], 24);
      if (pop_last && i == n - 1) begin
        check("pop_push_head", m_tdata, exp_data[0]);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        void'(exp_data.pop_front());
        void'(exp_last.pop_front());
      end
      model_word(fw[i], i == n - 1);
    end
  endtask

  task automatic drain(input string tag);
    m_tready = 1'b1;
    while (exp_data.size() > 0) begin
      int t;
      t = 0;
      while (!m_tvalid && t < 10) begin
        step();
        t++;
      end
      check({tag, "_valid"}, 32'(m_tvalid), 1);
      if (!m_tvalid) begin
        exp_data.delete();
        exp_last.delete();
        break;
      end
      check({tag, "_data"}, m_tdata, exp_data[0]);
      check({tag, "_last"}, 32'(m_tlast), 32'(exp_last[0]));
      void'(exp_data.pop_front());
      void'(exp_last.pop_front());
      step();
    end
    m_tready = 1'b0;
    step();
    check({tag, "_empty"}, 32'(m_tvalid), 0);
  endtask

  initial begin
    do_reset("reset");

    // Configuration frame yields nothing; the repeat of it is delivered.
    fw[0] = 24'hABCDE5;
    fw[1] = 24'h12345F;
    run_frame(2, 1'b0);
    repeat (3) step();
    check("discard_frame", 32'(m_tvalid), 0);
    run_frame(2, 1'b0);
    drain("frame2");

    repeat (3) begin
      int n;
      n = $urandom_range(1, 4);
      rand_words(n);
      run_frame(n, 1'b0);
      drain("rand");
      check("rand_frame_err", 32'(frame_err), 0);
      check("rand_overflow", 32'(overflow), 0);
    end

    // Six words into a four-entry buffer with no consumer.
    rand_words(6);
    run_frame(6, 1'b0);
    step();
    step();
    check("ovf_flag", 32'(overflow), 32'(ovf));
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(drops));
    repeat (3) begin
      check("stall_data", m_tdata, exp_data[0]);
      check("stall_last", 32'(m_tlast), 32'(exp_last[0]));
      step();
    end
    drain("ovf");

    // Full buffer: a pop coinciding with the write loses nothing.
    rand_words(4);
    run_frame(4, 1'b0);
    rand_words(1);
    run_frame(1, 1'b1);
    step();
    check("full_pop_push_drop", 32'(drop_cnt), 32'(drops));
    drain("full_pp");

    // Abort after 10 bits, then a clean frame.
    rand_words(2);
    pulse(4'd2);
    send_bits(fw[0], 10);
    pulse(4'd2);
    check("abort_frame_err", 32'(frame_err), 1);
    for (int i = 0; i < 2; i++) begin
      send_bits(fw[i], 24);
      model_word(fw[i], i == 1);
    end
    drain("abort");

    // Reset in the middle of a frame with a word already buffered.
    rand_words(2);
    pulse(4'd2);
    send_bits(fw[0], 24);
    send_bits(fw[1], 5);
    #2;
    do_reset("midreset");

    // Zero channels: rejected, FSM stays idle and ignores bits.
    pulse(4'd0);
    check("nchan0_frame_err", 32'(frame_err), 1);
    send_bits(24'($urandom), 24);
    step();
    step();
    check("nchan0_no_output", 32'(m_tvalid), 0);

    // Post-reset configuration frame is discarded.
    rand_words(1);
    run_frame(1, 1'b0);
    repeat (3) step();
    check("post_reset_discard", 32'(m_tvalid), 0);

    // Latency from last bit to m_tvalid.
    rand_words(1);
    pulse(4'd1);
    send_bits(fw[0], 24);
    check("latency_1cyc", 32'(m_tvalid), 0);
    step();
    check("latency_2cyc", 32'(m_tvalid), 1);
    model_word(fw[0], 1'b1);
    drain("latency");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
